if_fetch_controller: RTL and testbench

Sequences instruction fetch for the 5-stage MIPS pipeline. Owns the program counter, drives the combinational instruction memory address, and loads the IF/ID pipeline register. It also applies hazard-unit stalls, branch redirects and flushes, and inserts optional wait states for slower instruction memories.

---
 rtl/if_fetch_controller.sv | 91 +++++++++
 tb/tb_if_fetch_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch_controller.sv
// Instruction-fetch controller: owns the PC, drives the instruction memory address,
// loads IF/ID, and applies stalls, branch redirects and optional memory wait states.
module if_fetch_controller #(
    parameter logic [31:0] PC_RESET  = 32'd0,
    parameter int unsigned IMEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        fetch_busy_o
);

    localparam logic [2:0] WAIT_CNT = 3'(IMEM_WAIT);

    localparam logic [0:0] ST_WAIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [31:0] pc_q, pc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;

    logic [0:0]  state;
    logic [31:0] pc_plus4;

    // cnt saturates at WAIT_CNT, so equality alone distinguishes the two states
    assign state    = (cnt_q == WAIT_CNT) ? ST_READY : ST_WAIT;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;

        if (branch_taken_i) begin
            pc_d       = branch_target_i & ~32'd3;
            cnt_d      = '0;
            id_pc_d    = '0;
            id_instr_d = '0;
            id_valid_d = 1'b0;
        end else if (stall_i) begin
            // IF/ID and PC freeze, but the memory access keeps progressing
            if (state == ST_WAIT) begin
                cnt_d = cnt_q + 3'd1;
            end
        end else if (state == ST_READY) begin
            pc_d       = pc_plus4;
            cnt_d      = '0;
            id_pc_d    = pc_plus4;
            id_instr_d = imem_instr_i;
            id_valid_d = 1'b1;
        end else begin
            cnt_d      = cnt_q + 3'd1;
            id_instr_d = '0;
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= PC_RESET;
            cnt_q      <= '0;
            id_pc_q    <= '0;
            id_instr_q <= '0;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign if_id_pc_o    = id_pc_q;
    assign if_id_instr_o = id_instr_q;
    assign if_id_valid_o = id_valid_q;
    assign fetch_busy_o  = (state == ST_WAIT);

endmodule

// File: tb/tb_if_fetch_controller.sv
// Scoreboard bench for if_fetch_controller: three instances (no wait, two wait states,
// wrapping reset PC) driven with directed vectors; a negedge monitor checks the queue.
module tb_if_fetch_controller;

    typedef struct {
        int          sel;
        int          step;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_v   [3];
    logic        stall_v [3];
    logic        br_v    [3];
    logic [31:0] tgt_v   [3];
    logic [31:0] addr_v  [3];
    logic [31:0] instr_v [3];
    logic [31:0] pc_v    [3];
    logic [31:0] iid_v   [3];
    logic        valid_v [3];
    logic        busy_v  [3];

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    always #5 clk = ~clk;

    // Instruction memory model: every word is a fixed scramble of its address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign instr_v[0] = mem(addr_v[0]);
    assign instr_v[1] = mem(addr_v[1]);
    assign instr_v[2] = mem(addr_v[2]);

    if_fetch_controller #(.PC_RESET(32'd0), .IMEM_WAIT(0)) u_w0 (
        .clk(clk), .rst(rst_v[0]), .stall_i(stall_v[0]), .branch_taken_i(br_v[0]),
        .branch_target_i(tgt_v[0]), .imem_addr_o(addr_v[0]), .imem_instr_i(instr_v[0]),
        .if_id_pc_o(pc_v[0]), .if_id_instr_o(iid_v[0]), .if_id_valid_o(valid_v[0]),
        .fetch_busy_o(busy_v[0])
    );

    if_fetch_controller #(.PC_RESET(32'd0), .IMEM_WAIT(2)) u_w2 (
        .clk(clk), .rst(rst_v[1]), .stall_i(stall_v[1]), .branch_taken_i(br_v[1]),
        .branch_target_i(tgt_v[1]), .imem_addr_o(addr_v[1]), .imem_instr_i(instr_v[1]),
        .if_id_pc_o(pc_v[1]), .if_id_instr_o(iid_v[1]), .if_id_valid_o(valid_v[1]),
        .fetch_busy_o(busy_v[1])
    );

    if_fetch_controller #(.PC_RESET(32'hFFFF_FFF8), .IMEM_WAIT(0)) u_wrap (
        .clk(clk), .rst(rst_v[2]), .stall_i(stall_v[2]), .branch_taken_i(br_v[2]),
        .branch_target_i(tgt_v[2]), .imem_addr_o(addr_v[2]), .imem_instr_i(instr_v[2]),
        .if_id_pc_o(pc_v[2]), .if_id_instr_o(iid_v[2]), .if_id_valid_o(valid_v[2]),
        .fetch_busy_o(busy_v[2])
    );

    // Drive one cycle of inputs, then record what must be visible after that edge
    task automatic step(input int sel, input logic r, input logic s, input logic b,
                        input logic [31:0] tgt, input logic [31:0] ea, input logic [31:0] ep,
                        input logic [31:0] ei, input logic ev, input logic eb);
        exp_t e;
        rst_v[sel]   = r;
        stall_v[sel] = s;
        br_v[sel]    = b;
        tgt_v[sel]   = tgt;
        @(posedge clk);
        #1;
        step_no++;
        e.sel = sel; e.step = step_no; e.addr = ea; e.pc = ep;
        e.instr = ei; e.valid = ev; e.busy = eb;
        sb.push_back(e);
    endtask

    task automatic cmp32(input string nm, input exp_t e, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL dut%0d step%0d %s: got %h expected %h", e.sel, e.step, nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp32("imem_addr", e, addr_v[e.sel], e.addr);
            cmp32("if_id_pc", e, pc_v[e.sel], e.pc);
            cmp32("if_id_instr", e, iid_v[e.sel], e.instr);
            cmp32("if_id_valid", e, {31'd0, valid_v[e.sel]}, {31'd0, e.valid});
            cmp32("fetch_busy", e, {31'd0, busy_v[e.sel]}, {31'd0, e.busy});
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_v[k] = 1'b1; stall_v[k] = 1'b0; br_v[k] = 1'b0; tgt_v[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;

        // IMEM_WAIT=0: sequential fetch, stall, branch, branch+stall
        //   sel r  s  b  tgt           addr          if_id_pc      instr               v  busy
        step(0, 1, 0, 0, 32'd0,  32'd0,  32'd0,  32'd0,       0, 0);
        step(0, 0, 0, 0, 32'd0,  32'd4,  32'd4,  mem(32'd0),  1, 0);
        step(0, 0, 0, 0, 32'd0,  32'd8,  32'd8,  mem(32'd4),  1, 0);
        step(0, 0, 0, 0, 32'd0,  32'd12, 32'd12, mem(32'd8),  1, 0);
        step(0, 0, 1, 0, 32'd0,  32'd12, 32'd12, mem(32'd8),  1, 0);
        step(0, 0, 1, 0, 32'd0,  32'd12, 32'd12, mem(32'd8),  1, 0);
        step(0, 0, 1, 0, 32'd0,  32'd12, 32'd12, mem(32'd8),  1, 0);
        step(0, 0, 0, 0, 32'd0,  32'd16, 32'd16, mem(32'd12), 1, 0);
        step(0, 0, 0, 1, 32'd7,  32'd4,  32'd0,  32'd0,       0, 0);
        step(0, 0, 0, 0, 32'd0,  32'd8,  32'd8,  mem(32'd4),  1, 0);
        step(0, 0, 1, 1, 32'd20, 32'd20, 32'd0,  32'd0,       0, 0);
        step(0, 0, 0, 0, 32'd0,  32'd24, 32'd24, mem(32'd20), 1, 0);
        rst_v[0] = 1'b1;

        // IMEM_WAIT=2: wait states, stall release, reset mid-wait, redirect mid-wait
        step(1, 1, 0, 0, 32'd0,     32'd0,     32'd0,     32'd0,         0, 1);
        step(1, 0, 0, 0, 32'd0,     32'd0,     32'd0,     32'd0,         0, 1);
        step(1, 0, 0, 0, 32'd0,     32'd0,     32'd0,     32'd0,         0, 0);
        step(1, 0, 0, 0, 32'd0,     32'd4,     32'd4,     mem(32'd0),    1, 1);
        step(1, 0, 0, 0, 32'd0,     32'd4,     32'd4,     32'd0,         0, 1);
        step(1, 0, 0, 0, 32'd0,     32'd4,     32'd4,     32'd0,         0, 0);
        step(1, 0, 0, 0, 32'd0,     32'd8,     32'd8,     mem(32'd4),    1, 1);
        step(1, 0, 1, 0, 32'd0,     32'd8,     32'd8,     mem(32'd4),    1, 1);
        step(1, 0, 1, 0, 32'd0,     32'd8,     32'd8,     mem(32'd4),    1, 0);
        step(1, 0, 1, 0, 32'd0,     32'd8,     32'd8,     mem(32'd4),    1, 0);
        step(1, 0, 0, 0, 32'd0,     32'd12,    32'd12,    mem(32'd8),    1, 1);
        step(1, 0, 0, 0, 32'd0,     32'd12,    32'd12,    32'd0,         0, 1);
        step(1, 1, 0, 0, 32'd0,     32'd0,     32'd0,     32'd0,         0, 1);
        step(1, 0, 0, 0, 32'd0,     32'd0,     32'd0,     32'd0,         0, 1);
        step(1, 0, 0, 1, 32'h103,   32'h100,   32'd0,     32'd0,         0, 1);
        step(1, 0, 0, 0, 32'd0,     32'h100,   32'd0,     32'd0,         0, 1);
        step(1, 0, 0, 0, 32'd0,     32'h100,   32'd0,     32'd0,         0, 0);
        step(1, 0, 0, 0, 32'd0,     32'h104,   32'h104,   mem(32'h100),  1, 1);
        rst_v[1] = 1'b1;

        // PC wrap from the top of the address space
        step(2, 1, 0, 0, 32'd0, 32'hFFFF_FFF8, 32'd0,        32'd0,              0, 0);
        step(2, 0, 0, 0, 32'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, mem(32'hFFFF_FFF8), 1, 0);
        step(2, 0, 0, 0, 32'd0, 32'd0,         32'd0,         mem(32'hFFFF_FFFC), 1, 0);
        step(2, 0, 0, 0, 32'd0, 32'd4,         32'd4,         mem(32'd0),         1, 0);
        rst_v[2] = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
